wb_master_bridge: RTL and testbench
===================================

# wb_master_bridge

CPU-side front end of the Wishbone bus: converts the core's blocking load/store request into a single-beat Wishbone master cycle. The core stalls while the cycle is outstanding. Sits directly upstream of the Wishbone interconnect: it drives the interconnect's master STB/WE/ADDR/DAT inputs and consumes its master ACK and read data. It also provides alignment checking and an optional bus timeout.

## Interface
- TIMEOUT, 255: cycles in BUS state without ACK before the cycle is aborted; 8-bit counter; only used with the timeout feature.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- cpu_req  in  1  access request; held with addr/we/wdata stable until cpu_stall is low.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address; must be word-aligned.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data; valid in the cycle cpu_stall falls.
- cpu_stall  out  1  freeze pipeline.
- cpu_err  out  1  one-cycle pulse for a misaligned or timed-out access.
- wb_stb  out  1  to interconnect master_STB.
- wb_we  out  1  to interconnect master_WE.
- wb_addr  out  32  to interconnect master_ADDR.
- wb_dat_o  out  32  to interconnect master_DAT_I.
- wb_dat_i  in  32  from interconnect master_DAT_O.
- wb_ack  in  1  from interconnect master_ACK; may be combinational on wb_stb.

## Operation
- State machine: IDLE, BUS, DONE.
- IDLE:
  - If cpu_req and cpu_addr[1:0]==0: register addr, we and wdata into wb_addr, wb_we and wb_dat_o; go to BUS.
  - If cpu_req and the address is misaligned: set err_q=1 and rdata_q=0; go to DONE without any bus cycle.
- BUS:
  - wb_stb=1 and the wb_* outputs are held constant.
  - When wb_ack=1 is sampled: rdata_q <= wb_dat_i (for stores too; the core ignores it), err_q=0; go to DONE.
- DONE:
  - Lasts one cycle; cpu_stall=0, cpu_rdata=rdata_q, cpu_err=err_q.
  - Always returns to IDLE. A request held high in DONE is taken as already served; the core advances on the low stall.
- cpu_stall = cpu_req & (state != DONE), combinational.
- cpu_rdata holds its last value outside DONE.
- If cpu_req falls during BUS, the bus cycle still runs to ACK and the result is discarded.
- wb_ack outside BUS is ignored.
- Reset values: state=IDLE, wb_stb=0, wb_we=0, wb_addr=0, wb_dat_o=0, rdata_q=0, err_q=0, cpu_err=0, timeout counter=0.
- Reset mid-cycle: wb_stb is 0 after the reset edge and the pending access is dropped.

## Timing
- Zero-wait slave (ACK in the same cycle as STB):
  - req seen at edge 0; wb_stb high in cycle 1; DONE in cycle 2.
  - cpu_stall is high for 2 cycles.
- Slave with N wait states (ACK in the Nth STB cycle, N≥1): cpu_stall is high for N+1 cycles.
- Misaligned access: cpu_stall is high for 1 cycle, then err/DONE; wb_stb never asserts.
- Back-to-back requests: IDLE costs one cycle between accesses, so at most one access every 3 cycles.
- wb_stb is registered; it never glitches and never asserts in IDLE or DONE.

## Configuration
- WB_BRIDGE_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to BUS and increments each BUS cycle without ACK.
  - When it reaches TIMEOUT: wb_stb drops, rdata_q=32'h00000000, err_q=1, go to DONE.
  - If ACK arrives in the same cycle the count reaches TIMEOUT, ACK wins: normal completion, no error.
- Not defined: no counter. BUS waits indefinitely for ACK, and cpu_err pulses only for misaligned accesses.

## Test plan
- Store, zero-wait slave: req=1, we=1, addr=32'h10000000, wdata=32'h00002333, wb_ack tied to wb_stb -> wb_stb high exactly one cycle with wb_addr=32'h10000000, wb_dat_o=32'h00002333, wb_we=1; stall high 2 cycles; cpu_err=0.
- Load, 3 wait states: addr=32'h20000004, wb_dat_i=32'hCAFEF00D, ACK in the 3rd STB cycle -> stall high 4 cycles; cpu_rdata=32'hCAFEF00D in the release cycle.
- Misaligned: addr=32'h10000002 -> wb_stb stays 0; cpu_err pulses one cycle; stall high 1 cycle.
- Reset in BUS: rst=1 during the 2nd STB cycle -> wb_stb=0 and cpu_stall follows IDLE after the edge; a later request completes normally.
- Timeout with WB_BRIDGE_TIMEOUT_EN and TIMEOUT=4, ACK never asserted -> wb_stb high 4 cycles, then cpu_err=1 and cpu_rdata=0; without the macro, stall stays high for 1000 cycles.
- Back-to-back loads with req held through DONE -> each access produces exactly one STB burst, and consecutive STB bursts are 3 cycles apart for zero-wait slaves.

Source files
------------

// File: rtl/wb_master_bridge.sv
// Single-beat Wishbone master: turns a blocking CPU load/store into one STB/ACK cycle.
// Optional bus timeout is compiled in when WB_BRIDGE_TIMEOUT_EN is defined.
module wb_master_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_err,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2} state_t;

  state_t      state;
  logic [31:0] rdata_q;
  logic        err_q;

`ifdef WB_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] to_cnt;
`endif

  // DONE is the single release cycle; rdata_q only changes on entry to DONE,
  // so cpu_rdata naturally holds its last value everywhere else.
  assign cpu_stall = cpu_req & (state != DONE);
  assign cpu_rdata = rdata_q;
  assign cpu_err   = (state == DONE) & err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wb_stb   <= 1'b0;
      wb_we    <= 1'b0;
      wb_addr  <= '0;
      wb_dat_o <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef WB_BRIDGE_TIMEOUT_EN
      to_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (cpu_addr[1:0] == 2'b00) begin
              wb_addr  <= cpu_addr;
              wb_we    <= cpu_we;
              wb_dat_o <= cpu_wdata;
              wb_stb   <= 1'b1;
`ifdef WB_BRIDGE_TIMEOUT_EN
              to_cnt   <= '0;
`endif
              state    <= BUS;
            end else begin
              // Misaligned: report the error without touching the bus.
              err_q   <= 1'b1;
              rdata_q <= '0;
              state   <= DONE;
            end
          end
        end
        BUS: begin
          if (wb_ack) begin
            rdata_q <= wb_dat_i;
            err_q   <= 1'b0;
            wb_stb  <= 1'b0;
            state   <= DONE;
          end
`ifdef WB_BRIDGE_TIMEOUT_EN
          // ACK is tested first, so an ACK on the final counted cycle still wins.
          else if (to_cnt == TO_LAST) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            wb_stb  <= 1'b0;
            state   <= DONE;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Scoreboard bench for wb_master_bridge: directed cases plus randomized accesses
// against a transaction-level model (latency, error, read data, STB burst shape).
module tb_wb_master_bridge;

`ifdef WB_BRIDGE_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 0;
`endif
  localparam int TO_P = (TO > 0) ? TO : 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_err;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_addr;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack;

  int total = 0;
  int bad = 0;

  // Slave model: ACK in the ack_at-th cycle of an STB burst (0 = never).
  int ack_at = 0;
  int stb_cyc = 1;
  assign wb_ack = wb_stb && (ack_at != 0) && (stb_cyc == ack_at);
  always @(posedge clk) stb_cyc <= wb_stb ? stb_cyc + 1 : 1;

  always #5 clk = ~clk;

  wb_master_bridge #(.TIMEOUT(TO_P)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack(wb_ack)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          len;   // expected STB cycles, -1 = not checked
    int          gap;   // expected cycles since previous STB rise, 0 = not checked
  } bus_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          stall;
  } resp_t;

  bus_t  bus_q[$];
  resp_t resp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT shows an STB burst or a release cycle.
  int          cyc = 0;
  int          last_rise = -100;
  int          stall_cnt = 0;
  int          blen = 0;
  bit          in_burst = 0;
  bit          have = 0;
  bus_t        cur;
  resp_t       r;
  logic [31:0] last_rd = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      stall_cnt = 0;
      last_rd   = '0;
    end else if (cpu_req && cpu_stall) begin
      stall_cnt++;
      chk("err_while_stalled", 32'(cpu_err), 32'd0);
    end else if (cpu_req && !cpu_stall) begin
      if (resp_q.size() == 0) begin
        chk("unexpected_release", 32'd1, 32'd0);
      end else begin
        r = resp_q.pop_front();
        chk("resp_err", 32'(cpu_err), 32'(r.err));
        chk("resp_rdata", cpu_rdata, r.rdata);
        chk("resp_stall_cycles", 32'(stall_cnt), 32'(r.stall));
        last_rd = r.rdata;
      end
      stall_cnt = 0;
    end else begin
      chk("idle_err", 32'(cpu_err), 32'd0);
      chk("idle_rdata_hold", cpu_rdata, last_rd);
      stall_cnt = 0;
    end

    if (wb_stb === 1'b1) begin
      if (!in_burst) begin
        in_burst = 1;
        blen = 0;
        if (bus_q.size() == 0) begin
          have = 0;
          chk("unexpected_stb", 32'd1, 32'd0);
        end else begin
          cur = bus_q.pop_front();
          have = 1;
          if (cur.gap > 0) chk("stb_spacing", 32'(cyc - last_rise), 32'(cur.gap));
        end
        last_rise = cyc;
      end
      blen++;
      if (have) begin
        chk("wb_addr", wb_addr, cur.addr);
        chk("wb_we", 32'(wb_we), 32'(cur.we));
        chk("wb_dat_o", wb_dat_o, cur.wdata);
      end
    end else if (in_burst) begin
      in_burst = 0;
      if (have && cur.len >= 0) chk("stb_length", 32'(blen), 32'(cur.len));
    end
  end

  // Model of one access from the CPU's point of view.
  task automatic push_exp(input logic [31:0] a, input logic w, input logic [31:0] wd,
                          input logic [31:0] rd, input int ack, input int gap);
    bus_t  b;
    resp_t e;
    int    lat;
    bit    err;
    if (a[1:0] != 2'b00) begin
      e.err = 1'b1; e.rdata = '0; e.stall = 1;
      resp_q.push_back(e);
    end else begin
      lat = ack;
      err = 0;
      if (TO > 0 && (ack == 0 || ack > TO)) begin
        lat = TO;
        err = 1;
      end
      b.addr = a; b.we = w; b.wdata = wd; b.len = lat; b.gap = gap;
      bus_q.push_back(b);
      e.err = err; e.rdata = err ? 32'h0 : rd; e.stall = lat + 1;
      resp_q.push_back(e);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that ends DONE.
  task automatic do_access(input logic [31:0] a, input logic w, input logic [31:0] wd,
                           input logic [31:0] rd, input int ack, input bit hold, input int gap);
    int n;
    push_exp(a, w, wd, rd, ack, gap);
    cpu_req = 1'b1; cpu_we = w; cpu_addr = a; cpu_wdata = wd;
    wb_dat_i = rd; ack_at = ack;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cpu_stall && n < 600);
    if (cpu_stall) chk("access_never_released", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    if (!hold) cpu_req = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    bit          ok;
    bit          hold;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_wb_stb", 32'(wb_stb), 32'd0);
    chk("reset_wb_we", 32'(wb_we), 32'd0);
    chk("reset_wb_addr", wb_addr, 32'd0);
    chk("reset_wb_dat_o", wb_dat_o, 32'd0);
    chk("reset_cpu_rdata", cpu_rdata, 32'd0);
    chk("reset_cpu_err", 32'(cpu_err), 32'd0);
    chk("reset_cpu_stall", 32'(cpu_stall), 32'd0);

    @(posedge clk); #1;
    do_access(32'h10000000, 1'b1, 32'h00002333, 32'h5A5A0001, 1, 0, 0);
    do_access(32'h20000004, 1'b0, 32'h0, 32'hCAFEF00D, 3, 0, 0);
    do_access(32'h10000002, 1'b0, 32'h0, 32'h12345678, 1, 0, 0);

    // Reset during the second STB cycle; the access is dropped and a new one follows.
    @(posedge clk); #1;
    begin
      bus_t b;
      b.addr = 32'h40000010; b.we = 1'b0; b.wdata = 32'h0; b.len = 2; b.gap = 0;
      bus_q.push_back(b);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40000010; cpu_wdata = 32'h0; ack_at = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_mid_bus_stb", 32'(wb_stb), 32'd0);
    chk("rst_mid_bus_stall", 32'(cpu_stall), 32'd1);
    do_access(32'h40000020, 1'b0, 32'h0, 32'h0BADBEEF, 2, 0, 0);

`ifdef WB_BRIDGE_TIMEOUT_EN
    do_access(32'h50000000, 1'b0, 32'h0, 32'hDEADDEAD, 0, 0, 0);
    do_access(32'h50000004, 1'b0, 32'h0, 32'h600DF00D, TO, 0, 0);
`else
    begin
      bus_t b;
      b.addr = 32'h30000000; b.we = 1'b0; b.wdata = 32'h0; b.len = -1; b.gap = 0;
      bus_q.push_back(b);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30000000; ack_at = 0;
    @(negedge clk);
    ok = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!(cpu_stall && wb_stb)) ok = 0;
    end
    chk("no_timeout_hang", 32'(ok), 32'd1);
    @(posedge clk); #1 rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
`endif

    // Back-to-back zero-wait loads with the request held through DONE.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++)
      do_access(32'h60000000 + 32'(i * 4), 1'b0, 32'h0, 32'hA0000000 + 32'(i),
                1, (i < 3), (i == 0) ? 0 : 3);

    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      else a[1:0] = 2'b00;
      hold = ($urandom_range(0, 2) == 0) && (i < 149);
      do_access(a, 1'($urandom_range(0, 1)), $urandom, $urandom,
                $urandom_range(1, 6), hold, 0);
      if (!hold) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end

    cpu_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    chk("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
